// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: tracks in-flight destination writes per
// architectural register and stalls decode on RAW/WAW hazards until the
// producing result becomes forwardable.
module hazard_scoreboard #(
   parameter int NUM_REGS  = 32,
   parameter int LAT_WIDTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [4:0]           id_rs1_addr,
   input  logic [4:0]           id_rs2_addr,
   input  logic                 id_rs1_used,
   input  logic                 id_rs2_used,
   input  logic                 id_reg_write,
   input  logic [4:0]           id_rd_addr,
   input  logic [LAT_WIDTH-1:0] id_latency,
   input  logic                 wb_reg_write,
   input  logic [4:0]           wb_rd_addr,
   input  logic                 flush,
   output logic                 stall,
   output logic                 issue_fire,
   output logic [NUM_REGS-1:0]  pending_mask,
   output logic [15:0]          stall_count
);

   logic [NUM_REGS-1:0]  busy_q, busy_d;
   logic [LAT_WIDTH-1:0] cnt_q [NUM_REGS];
   logic [LAT_WIDTH-1:0] cnt_d [NUM_REGS];
   logic [15:0]          stall_count_q, stall_count_d;
   logic                 hazard;

   // A register blocks consumers only while its result is still in flight
   // and not yet forwardable; busy with cnt==0 means forwarding covers it.
   function automatic logic not_ready(input logic [4:0] a);
      return busy_q[a] && (cnt_q[a] != '0);
   endfunction

   // Latency countdown that stops at zero instead of wrapping.
   function automatic logic [LAT_WIDTH-1:0] dec_sat(input logic [LAT_WIDTH-1:0] v);
      return (v == '0) ? v : v - LAT_WIDTH'(1);
   endfunction

   // Event counter that holds at its maximum value.
   function automatic logic [15:0] inc_sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Hazard detection for both sources (RAW) and the destination (WAW).
   always_comb begin
      hazard = (id_rs1_used  && not_ready(id_rs1_addr)) ||
               (id_rs2_used  && not_ready(id_rs2_addr)) ||
               (id_reg_write && not_ready(id_rd_addr));
   end

   assign stall        = id_valid && !flush && hazard;
   assign issue_fire   = id_valid && !stall && !flush;
   assign pending_mask = busy_q;
   assign stall_count  = stall_count_q;

   // Next-state: countdown, then writeback clear, then issue (issue wins over
   // writeback to the same rd), then flush overriding everything; x0 pinned.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         busy_d[r] = busy_q[r];
         cnt_d[r]  = dec_sat(cnt_q[r]);
      end
      stall_count_d = stall ? inc_sat(stall_count_q) : stall_count_q;

      if (wb_reg_write && (wb_rd_addr != 5'd0)) begin
         busy_d[wb_rd_addr] = 1'b0;
         cnt_d[wb_rd_addr]  = '0;
      end

      if (issue_fire && id_reg_write && (id_rd_addr != 5'd0)) begin
         busy_d[id_rd_addr] = 1'b1;
         cnt_d[id_rd_addr]  = id_latency;
      end

      if (flush) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = 1'b0;
            cnt_d[r]  = '0;
         end
      end

      busy_d[0] = 1'b0;
      cnt_d[0]  = '0;
   end

   // State registers; reset discards all in-flight tracking immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q        <= '0;
         stall_count_q <= '0;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         busy_q        <= busy_d;
         stall_count_q <= stall_count_d;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      end
   end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count (x0 hardwired zero).
REQ-002 SHALL have parameter LAT_WIDTH, default 3, width of per-register latency counter; max latency MAX_LAT = 2**LAT_WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port id_valid  input  1  decode holds a valid instruction.
REQ-006 SHALL have ports id_rs1_addr, id_rs2_addr  input  5 each  decode source addresses.
REQ-007 SHALL have ports id_rs1_used, id_rs2_used  input  1 each  source actually read by instruction.
REQ-008 SHALL have port id_reg_write  input  1  instruction writes a destination.
REQ-009 SHALL have port id_rd_addr  input  5  decode destination address.
REQ-010 SHALL have port id_latency  input  LAT_WIDTH  cycles after issue until result is forwardable (0 = ALU, 1 = load, >1 = multi-cycle unit).
REQ-011 SHALL have ports wb_reg_write, wb_rd_addr  input  1 / 5  writeback retirement of a destination.
REQ-012 SHALL have port flush  input  1  pipeline flush (branch mispredict / trap).
REQ-013 SHALL have port stall  output  1  hold decode and fetch; combinational.
REQ-014 SHALL have port issue_fire  output  1  id_valid && !stall && !flush; combinational.
REQ-015 SHALL have port pending_mask  output  NUM_REGS  registered busy bit per register.
REQ-016 SHALL have port stall_count  output  16  registered saturating count of stall cycles.

Function
REQ-017 SHALL keep per register r: busy[r] (1 bit) and cnt[r] (LAT_WIDTH bits); busy[0] and cnt[0] constant 0.
REQ-018 SHALL define not_ready(r) = busy[r] && cnt[r] != 0, using current registered state only.
REQ-019 SHALL assert stall when id_valid && !flush && ((id_rs1_used && not_ready(id_rs1_addr)) || (id_rs2_used && not_ready(id_rs2_addr)) || (id_reg_write && not_ready(id_rd_addr))) (RAW and WAW).
REQ-020 SHALL never stall on x0 sources or destination.
REQ-021 SHALL decrement every nonzero cnt[r] by 1 each cycle, never wrapping below 0.
REQ-022 SHALL, on issue_fire && id_reg_write && id_rd_addr != 0, set busy[rd]=1 and cnt[rd]=id_latency in the next cycle (overrides decrement).
REQ-023 SHALL, on wb_reg_write && wb_rd_addr != 0, clear busy[wb_rd_addr] and cnt[wb_rd_addr] next cycle.
REQ-024 SHALL give same-cycle issue to rd priority over writeback clear of the same rd.
REQ-025 SHALL, on flush, clear all busy and cnt next cycle, force stall=0 and issue_fire=0 that cycle; flush overrides issue and writeback.
REQ-026 SHALL keep a busy register with cnt==0 (result in flight, forwardable) non-stalling until writeback clears it.
REQ-027 SHALL yield exactly id_latency stall cycles for a back-to-back dependent instruction (load: 1 bubble; ALU: 0).
REQ-028 SHALL increment stall_count each cycle stall=1, saturating at 16'hFFFF.
REQ-029 SHALL drive pending_mask[r] = busy[r].

Reset
REQ-030 SHALL, while rst=1, asynchronously clear all busy, cnt and stall_count; stall=0, pending_mask=0, stall_count=0.
REQ-031 SHALL discard any in-flight tracking when reset asserts mid-operation; first post-reset instruction never stalls.

Verification
REQ-032 SHALL cover load-use: issue rd=5 latency=1, next cycle rs1=5 used -> stall=1 one cycle, issue_fire on second cycle, stall_count=1.
REQ-033 SHALL cover multi-cycle: issue rd=7 latency=5, dependent rs2=7 waits -> exactly 5 stall cycles then issue; ALU rd=3 latency=0 dependent -> no stall.
REQ-034 SHALL cover WAW and x0: pending rd=9 latency=4, new write rd=9 -> stalls until cnt=0; issue rd=0 latency=7 -> pending_mask stays 0.
REQ-035 SHALL cover simultaneous issue rd=4 and wb rd=4 same cycle -> pending_mask[4]=1 afterwards.
REQ-036 SHALL cover flush with rd=2,6 pending and dependent stalled -> stall=0, issue_fire=0 that cycle, pending_mask=0 next cycle.
REQ-037 SHALL cover rst asserted mid-stall -> outputs zero immediately without clock; stall_count saturation checked by forcing 65536+ stall cycles -> 16'hFFFF.
